// File: rtl/wb_ram_arbiter_pkg.sv
// Shared definitions for the tagged-RAM Wishbone arbiter: size-select codes,
// sequencer state encodings and a legality helper.
package wb_ram_arbiter_pkg;

  localparam logic [3:0] WB_SEL_BYTE = 4'b0001;
  localparam logic [3:0] WB_SEL_HALF = 4'b0011;
  localparam logic [3:0] WB_SEL_WORD = 4'b1111;
  localparam logic [3:0] WB_SEL_TAG  = 4'b0101;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  function automatic logic sel_legal(input logic [3:0] sel);
    return (sel == WB_SEL_BYTE) || (sel == WB_SEL_HALF) ||
           (sel == WB_SEL_WORD) || (sel == WB_SEL_TAG);
  endfunction

endpackage

// File: rtl/wb_ram_arbiter_rr_arb2.sv
// Two-input round-robin pick: a lone requester wins; on a tie the port that
// was not served last wins. Purely combinational.
module wb_ram_arbiter_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone sequencer in front of the tagged RAM slave: registers the
// granted request, holds it through the slave's post-ack settle window and
// attributes tag-mismatch interrupts to the master that caused them.
module wb_ram_arbiter
  import wb_ram_arbiter_pkg::*;
#(
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_SEL_WIDTH  = 4,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m0_data_i,
  input  logic [WB_SEL_WIDTH-1:0]  m0_sel_i,
  input  logic                     m0_we_i,
  input  logic                     m0_cyc_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_check_tags_i,
  output logic                     m0_ack_o,
  output logic                     m0_err_o,
  output logic [WB_DATA_WIDTH-1:0] m0_data_o,
  input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m1_data_i,
  input  logic [WB_SEL_WIDTH-1:0]  m1_sel_i,
  input  logic                     m1_we_i,
  input  logic                     m1_cyc_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_check_tags_i,
  output logic                     m1_ack_o,
  output logic                     m1_err_o,
  output logic [WB_DATA_WIDTH-1:0] m1_data_o,
  output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
  output logic [WB_DATA_WIDTH-1:0] s_data_o,
  output logic [WB_SEL_WIDTH-1:0]  s_sel_o,
  output logic                     s_we_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_check_tags_o,
  input  logic                     s_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] s_data_i,
  input  logic                     s_tag_mismatch_i,
  input  logic                     clear_mismatch_i,
  output logic                     s_clear_mismatch_o,
  output logic [1:0]               grant_o,
  output logic [1:0]               mismatch_src_o
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [1:0]               state_q, state_d;
  logic [1:0]               grant_q;
  logic [1:0]               err_q;
  logic                     stb_q;
  logic                     abort_q;
  logic                     last_grant_q;
  logic                     last_owner_q;
  logic                     mm_prev_q;
  logic [1:0]               mm_src_q;
  logic [CntW-1:0]          cnt_q;
  logic [WB_ADDR_WIDTH-1:0] addr_q;
  logic [WB_DATA_WIDTH-1:0] data_q;
  logic [WB_SEL_WIDTH-1:0]  sel_q;
  logic                     we_q;
  logic                     check_q;

  logic [1:0]               req;
  logic [1:0]               pick;
  logic                     pick_idx;
  logic [WB_ADDR_WIDTH-1:0] pick_addr;
  logic [WB_DATA_WIDTH-1:0] pick_data;
  logic [WB_SEL_WIDTH-1:0]  pick_sel;
  logic                     pick_we;
  logic                     pick_check;
  logic                     pick_legal;
  logic                     arb_en;
  logic                     issue_start;
  logic                     err_start;
  logic                     ack_in;
  logic                     owner;
  logic                     owner_cyc;
  logic                     mm_owner;

  // A port whose error pulse is showing is masked so one bad request errors once.
  assign req = {m1_cyc_i & m1_stb_i & ~err_q[1], m0_cyc_i & m0_stb_i & ~err_q[0]};

  wb_ram_arbiter_rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (pick)
  );

  assign pick_idx   = pick[1];
  assign pick_addr  = pick_idx ? m1_addr_i       : m0_addr_i;
  assign pick_data  = pick_idx ? m1_data_i       : m0_data_i;
  assign pick_sel   = pick_idx ? m1_sel_i        : m0_sel_i;
  assign pick_we    = pick_idx ? m1_we_i         : m0_we_i;
  assign pick_check = pick_idx ? m1_check_tags_i : m0_check_tags_i;
  assign pick_legal = sel_legal(pick_sel);

  // The last settle cycle doubles as an arbitration slot so a waiting master's
  // strobe rises right after the slave's window closes.
  assign arb_en      = (state_q == ST_IDLE) || ((state_q == ST_SETTLE) && (cnt_q == '0));
  assign issue_start = arb_en && (pick != 2'b00) && pick_legal;
  assign err_start   = arb_en && (pick != 2'b00) && !pick_legal;
  assign ack_in      = (state_q == ST_ISSUE) && s_ack_i;

  assign owner     = grant_q[1];
  assign owner_cyc = owner ? m1_cyc_i : m0_cyc_i;
  assign mm_owner  = (state_q == ST_ISSUE) ? owner : last_owner_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (issue_start) state_d = ST_ISSUE;
      ST_ISSUE:  if (s_ack_i) state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == '0) state_d = issue_start ? ST_ISSUE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      err_q        <= 2'b00;
      stb_q        <= 1'b0;
      abort_q      <= 1'b0;
      last_grant_q <= 1'b1;
      last_owner_q <= 1'b0;
      mm_prev_q    <= 1'b0;
      mm_src_q     <= 2'b00;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      check_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_start ? pick : 2'b00;
      mm_prev_q <= s_tag_mismatch_i;

      if (issue_start) begin
        addr_q  <= pick_addr;
        data_q  <= pick_data;
        sel_q   <= pick_sel;
        we_q    <= pick_we;
        check_q <= pick_check && (pick_sel != WB_SEL_TAG);
        grant_q <= pick;
        stb_q   <= 1'b1;
        abort_q <= 1'b0;
      end else if (ack_in) begin
        stb_q        <= 1'b0;
        last_grant_q <= owner;
        last_owner_q <= owner;
        cnt_q        <= CntW'(SETTLE_CYCLES - 1);
      end else if (state_q == ST_SETTLE) begin
        if (cnt_q == '0) grant_q <= 2'b00;
        else cnt_q <= cnt_q - 1'b1;
      end

      // Owner gave up mid-cycle: finish with the slave but swallow its ack.
      if ((state_q == ST_ISSUE) && !owner_cyc) abort_q <= 1'b1;

      if (clear_mismatch_i) mm_src_q <= 2'b00;
      else if (s_tag_mismatch_i && !mm_prev_q) mm_src_q[mm_owner] <= 1'b1;
    end
  end

  assign s_addr_o           = addr_q;
  assign s_data_o           = data_q;
  assign s_sel_o            = sel_q;
  assign s_we_o             = we_q;
  assign s_cyc_o            = stb_q;
  assign s_stb_o            = stb_q;
  assign s_check_tags_o     = check_q;
  assign s_clear_mismatch_o = clear_mismatch_i;
  assign grant_o            = grant_q;
  assign mismatch_src_o     = mm_src_q;

  assign m0_ack_o  = ack_in && grant_q[0] && !abort_q && m0_cyc_i;
  assign m1_ack_o  = ack_in && grant_q[1] && !abort_q && m1_cyc_i;
  assign m0_err_o  = err_q[0];
  assign m1_err_o  = err_q[1];
  assign m0_data_o = grant_q[0] ? s_data_i : '0;
  assign m1_data_o = grant_q[1] ? s_data_i : '0;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: a behavioural tagged-RAM slave plus a serial
// reference model of memory, tags, round-robin order and mismatch attribution.
module tb_wb_ram_arbiter;
  import wb_ram_arbiter_pkg::*;

  localparam int unsigned Settle = 3;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [31:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [3:0]  m_sel  [2];
  logic [1:0]  m_we, m_cyc, m_stb, m_chk, m_ack, m_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] s_addr_o, s_data_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_check_tags_o, s_clear_mismatch_o;
  logic        clear_mismatch_i;
  logic [1:0]  grant_o, mismatch_src_o;
  logic        slv_ack, slv_irq;
  logic [31:0] slv_rdata;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_ram_arbiter #(
    .WB_DATA_WIDTH (32),
    .WB_ADDR_WIDTH (32),
    .WB_SEL_WIDTH  (4),
    .SETTLE_CYCLES (Settle)
  ) dut (
    .wb_clk_i           (wb_clk_i),
    .wb_rst_i           (wb_rst_i),
    .m0_addr_i          (m_addr[0]),
    .m0_data_i          (m_data[0]),
    .m0_sel_i           (m_sel[0]),
    .m0_we_i            (m_we[0]),
    .m0_cyc_i           (m_cyc[0]),
    .m0_stb_i           (m_stb[0]),
    .m0_check_tags_i    (m_chk[0]),
    .m0_ack_o           (m_ack[0]),
    .m0_err_o           (m_err[0]),
    .m0_data_o          (m0_rdata),
    .m1_addr_i          (m_addr[1]),
    .m1_data_i          (m_data[1]),
    .m1_sel_i           (m_sel[1]),
    .m1_we_i            (m_we[1]),
    .m1_cyc_i           (m_cyc[1]),
    .m1_stb_i           (m_stb[1]),
    .m1_check_tags_i    (m_chk[1]),
    .m1_ack_o           (m_ack[1]),
    .m1_err_o           (m_err[1]),
    .m1_data_o          (m1_rdata),
    .s_addr_o           (s_addr_o),
    .s_data_o           (s_data_o),
    .s_sel_o            (s_sel_o),
    .s_we_o             (s_we_o),
    .s_cyc_o            (s_cyc_o),
    .s_stb_o            (s_stb_o),
    .s_check_tags_o     (s_check_tags_o),
    .s_ack_i            (slv_ack),
    .s_data_i           (slv_rdata),
    .s_tag_mismatch_i   (slv_irq),
    .clear_mismatch_i   (clear_mismatch_i),
    .s_clear_mismatch_o (s_clear_mismatch_o),
    .grant_o            (grant_o),
    .mismatch_src_o     (mismatch_src_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hCAFE_BABE;
    if (i == 8) return 32'h1122_3344;
    return 32'(i) * 32'h9E37_79B1;
  endfunction

  // Size-coded write: data sits in the low bits, the address picks the lane.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] lo,
                                        input logic [3:0] sel, input logic [31:0] wd);
    logic [31:0] msk, val;
    if (sel == WB_SEL_BYTE) begin
      msk = 32'hFF << (8 * lo);
      val = (wd & 32'hFF) << (8 * lo);
    end else if (sel == WB_SEL_HALF) begin
      msk = 32'hFFFF << (16 * lo[1]);
      val = (wd & 32'hFFFF) << (16 * lo[1]);
    end else begin
      msk = 32'hFFFF_FFFF;
      val = wd;
    end
    return (old & ~msk) | (val & msk);
  endfunction

  // Behavioural slave: ack one cycle after strobe, sticky tag-mismatch irq.
  logic [31:0] mem [64];
  logic [3:0]  tag_mem [16];
  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      slv_ack   <= 1'b0;
      slv_irq   <= 1'b0;
      slv_rdata <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      for (int i = 0; i < 16; i++) tag_mem[i] <= 4'h0;
    end else begin
      if (s_clear_mismatch_o) slv_irq <= 1'b0;
      if (s_cyc_o && s_stb_o && !slv_ack) begin
        slv_ack <= 1'b1;
        if (s_sel_o == WB_SEL_TAG) begin
          if (s_we_o) tag_mem[s_addr_o[7:4]] <= s_data_o[3:0];
          slv_rdata <= {28'h0, tag_mem[s_addr_o[7:4]]};
        end else begin
          if (s_check_tags_o && (s_addr_o[31:28] != tag_mem[s_addr_o[7:4]])) slv_irq <= 1'b1;
          if (s_we_o)
            mem[s_addr_o[7:2]] <= merge(mem[s_addr_o[7:2]], s_addr_o[1:0], s_sel_o, s_data_o);
          slv_rdata <= mem[s_addr_o[7:2]];
        end
      end else begin
        slv_ack <= 1'b0;
      end
    end
  end

  // Reference model: accesses applied one at a time in the order they are served.
  logic [31:0] ref_mem [64];
  logic [3:0]  ref_tag [16];
  int          ref_last;
  logic [1:0]  ref_mm;

  logic [31:0] op_addr [2];
  logic [31:0] op_data [2];
  logic [3:0]  op_sel  [2];
  logic [1:0]  op_we, op_chk;

  function automatic logic [31:0] ref_access(input int p);
    logic [5:0] idx;
    logic [3:0] gran;
    idx  = op_addr[p][7:2];
    gran = op_addr[p][7:4];
    if (op_sel[p] == WB_SEL_TAG) begin
      if (op_we[p]) ref_tag[gran] = op_data[p][3:0];
      return op_we[p] ? 32'h0 : {28'h0, ref_tag[gran]};
    end
    if (op_chk[p] && (op_addr[p][31:28] != ref_tag[gran])) ref_mm[p] = 1'b1;
    if (op_we[p]) begin
      ref_mem[idx] = merge(ref_mem[idx], op_addr[p][1:0], op_sel[p], op_data[p]);
      return 32'h0;
    end
    return ref_mem[idx];
  endfunction

  function automatic logic [31:0] rd(input int p);
    return (p == 0) ? m0_rdata : m1_rdata;
  endfunction

  task automatic do_reset();
    wb_rst_i = 1'b1;
    m_cyc = 2'b00;
    m_stb = 2'b00;
    clear_mismatch_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < 16; i++) ref_tag[i] = 4'h0;
    ref_last = 1;
    ref_mm   = 2'b00;
    wb_rst_i = 1'b0;
  endtask

  task automatic set_op(input int p, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic w, input logic c);
    op_addr[p] = a;
    op_data[p] = d;
    op_sel[p]  = s;
    op_we[p]   = w;
    op_chk[p]  = c;
  endtask

  // Issue the enabled ops together, then check order, latency, data and hold window.
  task automatic run_pair(input logic [1:0] en);
    int         first, second, last, t, first_ack;
    int         ack_t [2];
    logic [31:0] exp_rd [2];
    logic [1:0] done, drop;
    first  = (en == 2'b11) ? ((ref_last == 0) ? 1 : 0) : (en[1] ? 1 : 0);
    second = 1 - first;
    exp_rd[first] = ref_access(first);
    if (en == 2'b11) exp_rd[second] = ref_access(second);
    last = (en == 2'b11) ? second : first;
    ref_last = last;
    @(negedge wb_clk_i);
    for (int p = 0; p < 2; p++) begin
      if (en[p]) begin
        m_addr[p] = op_addr[p];
        m_data[p] = op_data[p];
        m_sel[p]  = op_sel[p];
        m_we[p]   = op_we[p];
        m_chk[p]  = op_chk[p];
        m_cyc[p]  = 1'b1;
        m_stb[p]  = 1'b1;
      end
    end
    done = 2'b00;
    t = 0;
    first_ack = -1;
    ack_t[0] = 0;
    ack_t[1] = 0;
    while ((done != en) && (t < 40)) begin
      @(negedge wb_clk_i);
      t++;
      drop = 2'b00;
      for (int p = 0; p < 2; p++) begin
        if (m_ack[p]) begin
          check_eq("nonowner_ack", 32'(m_ack[1-p]), 32'h0);
          check_eq("nonowner_data", rd(1 - p), 32'h0);
          if (!op_we[p]) check_eq("rdata", rd(p), exp_rd[p]);
          if (first_ack < 0) first_ack = p;
          ack_t[p] = t;
          done[p]  = 1'b1;
          drop[p]  = 1'b1;
        end
      end
      @(posedge wb_clk_i);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (drop[p]) begin
          m_cyc[p] = 1'b0;
          m_stb[p] = 1'b0;
        end
      end
    end
    check_eq("all_served", 32'(done), 32'(en));
    check_eq("first_served", 32'(first_ack), 32'(first));
    check_eq("first_latency", 32'(ack_t[first]), 32'd2);
    if (en == 2'b11) check_eq("second_gap", 32'(ack_t[second] - ack_t[first]), Settle + 2);
    for (int i = 0; i < int'(Settle); i++) begin
      @(negedge wb_clk_i);
      check_eq("settle_stb", 32'(s_stb_o), 32'h0);
      check_eq("hold_addr", s_addr_o, op_addr[last]);
      check_eq("hold_data", s_data_o, op_data[last]);
      check_eq("hold_sel", 32'(s_sel_o), 32'(op_sel[last]));
      check_eq("hold_we", 32'(s_we_o), 32'(op_we[last]));
      check_eq("hold_chk", 32'(s_check_tags_o),
               32'(op_chk[last] && (op_sel[last] != WB_SEL_TAG)));
    end
    repeat (2) @(negedge wb_clk_i);
    check_eq("grant_idle", 32'(grant_o), 32'h0);
    check_eq("mismatch_src", 32'(mismatch_src_o), 32'(ref_mm));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        stb_seen;
    logic [31:0] a;
    logic [3:0]  s;
    logic        w;
    logic [1:0]  en;
    m_cyc = 2'b00;
    m_stb = 2'b00;
    m_we  = 2'b00;
    m_chk = 2'b00;
    for (int p = 0; p < 2; p++) begin
      m_addr[p] = '0;
      m_data[p] = '0;
      m_sel[p]  = '0;
    end
    clear_mismatch_i = 1'b0;
    do_reset();

    check_eq("rst_grant", 32'(grant_o), 32'h0);
    check_eq("rst_stb", 32'(s_stb_o), 32'h0);
    check_eq("rst_cyc", 32'(s_cyc_o), 32'h0);
    check_eq("rst_acks", 32'(m_ack), 32'h0);
    check_eq("rst_errs", 32'(m_err), 32'h0);
    check_eq("rst_mm", 32'(mismatch_src_o), 32'h0);
    check_eq("rst_addr", s_addr_o, 32'h0);

    // Tie straight after reset: port 0 first, port 1 follows after the settle window.
    set_op(0, 32'h10, 32'h0, WB_SEL_WORD, 1'b0, 1'b0);
    set_op(1, 32'h20, 32'h0, WB_SEL_WORD, 1'b0, 1'b0);
    run_pair(2'b11);

    set_op(0, 32'h10, 32'h0, WB_SEL_WORD, 1'b0, 1'b0);
    run_pair(2'b01);

    set_op(1, 32'h21, 32'hAB, WB_SEL_BYTE, 1'b1, 1'b0);
    run_pair(2'b10);
    set_op(1, 32'h20, 32'h0, WB_SEL_WORD, 1'b0, 1'b0);
    run_pair(2'b10);

    // Tag write (check request must be stripped), then a mis-tagged checked load.
    set_op(1, 32'h40, 32'h5, WB_SEL_TAG, 1'b1, 1'b1);
    run_pair(2'b10);
    set_op(1, 32'h1000_0040, 32'h0, WB_SEL_WORD, 1'b0, 1'b1);
    run_pair(2'b10);
    check_eq("mm_attrib", 32'(mismatch_src_o), 32'h2);
    @(negedge wb_clk_i);
    clear_mismatch_i = 1'b1;
    #1;
    check_eq("clear_fwd", 32'(s_clear_mismatch_o), 32'h1);
    @(posedge wb_clk_i);
    #1;
    clear_mismatch_i = 1'b0;
    ref_mm = 2'b00;
    @(negedge wb_clk_i);
    check_eq("mm_cleared", 32'(mismatch_src_o), 32'h0);

    // Illegal select: one-cycle error, no slave access.
    @(negedge wb_clk_i);
    m_addr[0] = 32'h10;
    m_sel[0]  = 4'b0110;
    m_we[0]   = 1'b0;
    m_chk[0]  = 1'b0;
    m_cyc[0]  = 1'b1;
    m_stb[0]  = 1'b1;
    @(negedge wb_clk_i);
    check_eq("err_pulse", 32'(m_err), 32'h1);
    check_eq("err_grant", 32'(grant_o), 32'h0);
    stb_seen = s_stb_o;
    @(posedge wb_clk_i);
    #1;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge wb_clk_i);
      stb_seen = stb_seen | s_stb_o;
      if (i == 0) check_eq("err_once", 32'(m_err), 32'h0);
    end
    check_eq("err_no_stb", 32'(stb_seen), 32'h0);

    // Reset in the middle of an access.
    @(negedge wb_clk_i);
    m_addr[0] = 32'h10;
    m_sel[0]  = WB_SEL_WORD;
    m_cyc[0]  = 1'b1;
    m_stb[0]  = 1'b1;
    @(negedge wb_clk_i);
    check_eq("pre_rst_stb", 32'(s_stb_o), 32'h1);
    wb_rst_i = 1'b1;
    #1;
    check_eq("rst_mid_stb", 32'(s_stb_o), 32'h0);
    check_eq("rst_mid_grant", 32'(grant_o), 32'h0);
    check_eq("rst_mid_acks", 32'(m_ack), 32'h0);
    do_reset();
    set_op(0, 32'h10, 32'h0, WB_SEL_WORD, 1'b0, 1'b0);
    run_pair(2'b01);

    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 2; p++) begin
        w = 1'($urandom_range(0, 1));
        a = 32'($urandom_range(0, 63)) << 2;
        s = WB_SEL_WORD;
        if (w) begin
          case ($urandom_range(0, 2))
            0: begin s = WB_SEL_BYTE; a[1:0] = 2'($urandom_range(0, 3)); end
            1: begin s = WB_SEL_HALF; a[1] = 1'($urandom_range(0, 1)); end
            default: s = WB_SEL_WORD;
          endcase
        end
        set_op(p, a, $urandom, s, w, 1'b0);
      end
      en = 2'($urandom_range(1, 3));
      run_pair(en);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
